// File: rtl/l2_request_scheduler.sv
// rtl/l2_request_scheduler.sv - L2 request channel arbiter with ongoing-request source FIFO
//
// Shares one L2 request channel between L1 demand misses (source 0) and the
// stream-buffer prefetch queue (sources 1..N). One request is issued at a time.
// Each accepted request's source is kept in an ongoing FIFO whose head is
// presented on DATA_FROM_L2_SRC.
//
// Optional feature: define STARVATION_GUARD_EN to let a pending prefetch win
// after MAX_DEMAND_RUN consecutive demand grants.
//
// Ports:
//   CLK, RSTN (async active-low), ENB (clock enable, freezes all state)
//   DEMAND_VALID/ADDR in, DEMAND_READY out      - L1 miss path
//   PREFETCH_QUEUE_EMPTY/ADDR/SRC in, _RD_ENB out - prefetch queue head
//   L2_REQ_VALID/ADDR/SRC out, L2_REQ_READY in  - L2 request channel
//   ONGOING_QUEUE_RD_ENB in                     - pop ongoing FIFO head
//   DATA_FROM_L2_SRC, ONGOING_FULL, ONGOING_EMPTY out
module l2_request_scheduler #(
    parameter int ADDR_WIDTH     = 26,
    parameter int N              = 3,
    parameter int q              = 2,
    parameter int MAX_DEMAND_RUN = 4,
    localparam int SRC_BITS      = $clog2(N + 1)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  ENB,
    input  logic                  DEMAND_VALID,
    input  logic [ADDR_WIDTH-1:0] DEMAND_ADDR,
    output logic                  DEMAND_READY,
    input  logic                  PREFETCH_QUEUE_EMPTY,
    input  logic [ADDR_WIDTH-1:0] PREFETCH_QUEUE_ADDR,
    input  logic [SRC_BITS-1:0]   PREFETCH_QUEUE_SRC,
    output logic                  PREFETCH_QUEUE_RD_ENB,
    output logic                  L2_REQ_VALID,
    input  logic                  L2_REQ_READY,
    output logic [ADDR_WIDTH-1:0] L2_REQ_ADDR,
    output logic [SRC_BITS-1:0]   L2_REQ_SRC,
    input  logic                  ONGOING_QUEUE_RD_ENB,
    output logic [SRC_BITS-1:0]   DATA_FROM_L2_SRC,
    output logic                  ONGOING_FULL,
    output logic                  ONGOING_EMPTY
);

    localparam int DEPTH = 1 << q;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state_q;
    logic [SRC_BITS-1:0]   fifo_q [DEPTH];
    logic [q-1:0]          wr_ptr_q, rd_ptr_q;
    logic [q:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [SRC_BITS-1:0]   src_q;

    logic grant, pick_pf, push, pop;

    assign ONGOING_FULL  = (count_q == (q+1)'(DEPTH));
    assign ONGOING_EMPTY = (count_q == '0);

    assign grant = ENB && (state_q == IDLE) && !ONGOING_FULL &&
                   (DEMAND_VALID || !PREFETCH_QUEUE_EMPTY);

`ifdef STARVATION_GUARD_EN
    localparam int RUN_BITS = $clog2(MAX_DEMAND_RUN + 1);
    logic [RUN_BITS-1:0] run_q;

    // Prefetch wins when no demand is waiting, or when demand has held the
    // channel for MAX_DEMAND_RUN grants while prefetches were waiting.
    assign pick_pf = !PREFETCH_QUEUE_EMPTY &&
                     (!DEMAND_VALID || (run_q == RUN_BITS'(MAX_DEMAND_RUN)));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            run_q <= '0;
        end else if (grant) begin
            if (pick_pf || PREFETCH_QUEUE_EMPTY)
                run_q <= '0;
            else if (run_q != RUN_BITS'(MAX_DEMAND_RUN))
                run_q <= run_q + 1'b1;
        end
    end
`else
    logic unused_max_run;
    assign unused_max_run = ^MAX_DEMAND_RUN;

    assign pick_pf = !PREFETCH_QUEUE_EMPTY && !DEMAND_VALID;
`endif

    assign DEMAND_READY          = grant && !pick_pf;
    assign PREFETCH_QUEUE_RD_ENB = grant && pick_pf;
    assign L2_REQ_VALID          = ENB && (state_q == ISSUE);
    assign L2_REQ_ADDR           = addr_q;
    assign L2_REQ_SRC            = src_q;

    // FIFO space was checked at grant time, so push never overflows.
    assign push = ENB && (state_q == ISSUE) && L2_REQ_READY;
    assign pop  = ENB && ONGOING_QUEUE_RD_ENB && !ONGOING_EMPTY;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    assign DATA_FROM_L2_SRC = ONGOING_EMPTY ? '0 : fifo_q[rd_ptr_q];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            src_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++)
                fifo_q[i] <= '0;
        end else if (ENB) begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        addr_q  <= pick_pf ? PREFETCH_QUEUE_ADDR : DEMAND_ADDR;
                        src_q   <= pick_pf ? PREFETCH_QUEUE_SRC  : '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (L2_REQ_READY)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (push) begin
                fifo_q[wr_ptr_q] <= src_q;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule
